// File: rtl/jtpang_sndwr_sched.sv
`timescale 1ns/1ps
// jtpang_sndwr_sched
// Write scheduler between the main CPU and the sound chips (jtopll FM and
// jt6295 PCM). CPU writes are captured into a small FIFO. They are replayed
// to the chips with a per-chip recovery gap, and the gap is counted in fm_cen
// ticks. A one-entry skid register absorbs a write that arrives while the FIFO
// is full. The CPU is held with cpu_wait_n until that entry drains.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   fm_cen              4 MHz enable, timing base for the scheduler
//   cpu_dout/cpu_a0     CPU write data and address bit 0
//   cpu_wr_n            CPU write strobe (active low)
//   fm_cs/pcm_cs        CPU chip selects (FM wins when both are high)
//   cpu_wait_n          low stalls the CPU while the skid entry is pending
//   chip_din/chip_a0    data/address towards the chips
//   fm_cs_o/pcm_cs_o    chip selects towards jtopll/jt6295
//   chip_wr_n           write strobe towards both chips
//   busy                queued, pending or in-flight write present
//   stall_cnt           number of writes that entered the skid register
//
// Optional feature: define JTPANG_SNDSCHED_STATS_EN to build the saturating
// stall counter. Without it stall_cnt is tied to zero.

module jtpang_sndwr_sched #(
   parameter int unsigned AW       = 2,
   parameter int unsigned FM_AWAIT = 12,
   parameter int unsigned FM_DWAIT = 84,
   parameter int unsigned PCM_WAIT = 16
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       fm_cen,
   input  logic [7:0] cpu_dout,
   input  logic       cpu_a0,
   input  logic       cpu_wr_n,
   input  logic       fm_cs,
   input  logic       pcm_cs,
   output logic       cpu_wait_n,
   output logic [7:0] chip_din,
   output logic       chip_a0,
   output logic       fm_cs_o,
   output logic       pcm_cs_o,
   output logic       chip_wr_n,
   output logic       busy,
   output logic [7:0] stall_cnt
);

   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned CNTW  = AW + 1;
   localparam int unsigned CW    = 8;

   typedef struct packed {
      logic       tgt;   // 1: FM, 0: PCM
      logic       a0;
      logic [7:0] data;
   } entry_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   // ---------------------------------------------------------------- capture
   logic    wr_n_d;
   logic    ev_c;
   entry_t  ev_entry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_n_d <= 1'b1;
      else        wr_n_d <= cpu_wr_n;
   end

   // One event per strobe: only the high-to-low transition counts
   assign ev_c = wr_n_d & ~cpu_wr_n & (fm_cs | pcm_cs);

   always_comb begin
      ev_entry      = '0;
      ev_entry.tgt  = fm_cs;
      ev_entry.a0   = cpu_a0;
      ev_entry.data = cpu_dout;
   end

   // ---------------------------------------------------------------- FIFO
   entry_t            mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CNTW-1:0]   count, count_nxt;
   logic              full, empty;
   logic              skid_v, skid_v_nxt;
   entry_t            skid_d;
   logic              pop, can_push, push, push_ev, push_skid, skid_load;
   entry_t            push_data, head;
   state_t            state, state_nxt;

   assign full      = (count == CNTW'(DEPTH));
   assign empty     = (count == '0);
   assign head      = mem[rd_ptr];
   assign pop       = (state == ST_IDLE) & ~empty;
   // A pop in the same cycle frees the slot a push needs
   assign can_push  = ~full | pop;
   assign push_skid = skid_v & can_push;
   assign push_ev   = ev_c & ~skid_v & can_push;
   // A new event moves into the skid when it cannot go straight to the FIFO
   assign skid_load = ev_c & (skid_v ? push_skid : ~can_push);
   assign push      = push_skid | push_ev;
   assign push_data = skid_v ? skid_d : ev_entry;
   assign skid_v_nxt = skid_load | (skid_v & ~push_skid);
   assign count_nxt = count + CNTW'(push) - CNTW'(pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         skid_v <= 1'b0;
         skid_d <= '0;
      end else begin
         if (push)      wr_ptr <= wr_ptr + AW'(1);
         if (pop)       rd_ptr <= rd_ptr + AW'(1);
         if (skid_load) skid_d <= ev_entry;
         count  <= count_nxt;
         skid_v <= skid_v_nxt;
      end
   end

   // ---------------------------------------------------------------- scheduler
   logic [CW-1:0] wcnt, wcnt_nxt, wait_sel;
   logic [7:0]    din_nxt;
   logic          a0_nxt, fmcs_nxt, pcmcs_nxt, wr_n_nxt, busy_nxt;

   // The entry in flight is identified by the registered selects and a0
   always_comb begin
      if (fm_cs_o) wait_sel = chip_a0 ? CW'(FM_DWAIT) : CW'(FM_AWAIT);
      else         wait_sel = CW'(PCM_WAIT);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (!empty)                   state_nxt = ST_LOAD;
         ST_LOAD:   if (fm_cen)                   state_nxt = ST_STROBE;
         ST_STROBE: if (fm_cen)                   state_nxt = ST_HOLD;
         ST_HOLD:   if (fm_cen && wcnt == '0)     state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: next values of the registered chip-side signals
   always_comb begin
      din_nxt   = chip_din;
      a0_nxt    = chip_a0;
      fmcs_nxt  = fm_cs_o;
      pcmcs_nxt = pcm_cs_o;
      wcnt_nxt  = wcnt;
      wr_n_nxt  = 1'b1;
      unique case (state)
         ST_IDLE: begin
            if (!empty) begin
               din_nxt   = head.data;
               a0_nxt    = head.a0;
               fmcs_nxt  = head.tgt;
               pcmcs_nxt = ~head.tgt;
            end
         end
         ST_LOAD: begin
            wr_n_nxt = ~fm_cen;
         end
         ST_STROBE: begin
            // Strobe lasts until the next fm_cen, which also arms the gap
            wr_n_nxt = fm_cen;
            if (fm_cen) wcnt_nxt = wait_sel;
         end
         ST_HOLD: begin
            if (fm_cen) begin
               fmcs_nxt  = 1'b0;
               pcmcs_nxt = 1'b0;
               if (wcnt != '0) wcnt_nxt = wcnt - CW'(1);
            end
         end
      endcase
      busy_nxt = (count_nxt != '0) | (state_nxt != ST_IDLE) | skid_v_nxt;
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt       <= '0;
         chip_din   <= 8'd0;
         chip_a0    <= 1'b0;
         fm_cs_o    <= 1'b0;
         pcm_cs_o   <= 1'b0;
         chip_wr_n  <= 1'b1;
         busy       <= 1'b0;
         cpu_wait_n <= 1'b1;
      end else begin
         wcnt       <= wcnt_nxt;
         chip_din   <= din_nxt;
         chip_a0    <= a0_nxt;
         fm_cs_o    <= fmcs_nxt;
         pcm_cs_o   <= pcmcs_nxt;
         chip_wr_n  <= wr_n_nxt;
         busy       <= busy_nxt;
         cpu_wait_n <= ~skid_v_nxt;
      end
   end

   // ---------------------------------------------------------------- stats
`ifdef JTPANG_SNDSCHED_STATS_EN
   logic [7:0] stall_q;

   // Saturating count of writes that had to wait in the skid register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             stall_q <= 8'd0;
      else if (skid_load && stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_jtpang_sndwr_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for jtpang_sndwr_sched. Issued CPU writes are pushed as
// expected chip writes. A monitor pops one entry per chip strobe and checks
// the target, data, strobe width and minimum spacing.

module tb_jtpang_sndwr_sched;

   typedef struct packed {
      logic       tgt;
      logic       a0;
      logic [7:0] d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       fm_cen;
   logic [7:0] cpu_dout;
   logic       cpu_a0;
   logic       cpu_wr_n;
   logic       fm_cs;
   logic       pcm_cs;
   logic       cpu_wait_n;
   logic [7:0] chip_din;
   logic       chip_a0;
   logic       fm_cs_o;
   logic       pcm_cs_o;
   logic       chip_wr_n;
   logic       busy;
   logic [7:0] stall_cnt;

   jtpang_sndwr_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fm_cen     (fm_cen),
      .cpu_dout   (cpu_dout),
      .cpu_a0     (cpu_a0),
      .cpu_wr_n   (cpu_wr_n),
      .fm_cs      (fm_cs),
      .pcm_cs     (pcm_cs),
      .cpu_wait_n (cpu_wait_n),
      .chip_din   (chip_din),
      .chip_a0    (chip_a0),
      .fm_cs_o    (fm_cs_o),
      .pcm_cs_o   (pcm_cs_o),
      .chip_wr_n  (chip_wr_n),
      .busy       (busy),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          errors  = 0;
   exp_t        exp_q[$];
   int unsigned fall_ticks[$];
   int unsigned ticks = 0;
   int unsigned n_strobes = 0;
   bit          rand_cen = 1'b0;
   int          cen_div = 0;
   bit          fm_seen = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Required idle gap after a chip write, straight from the chip rules
   function automatic int unsigned gap_of(input exp_t e);
      if (e.tgt) return e.a0 ? 84 : 12;
      return 16;
   endfunction

   // fm_cen generation: fixed 1-in-4 or random
   always @(negedge clk) begin
      if (rand_cen) fm_cen = ($urandom_range(0, 2) == 0);
      else begin
         cen_div = (cen_div == 3) ? 0 : cen_div + 1;
         fm_cen  = (cen_div == 0);
      end
   end

   always @(posedge clk) if (fm_cen) ticks <= ticks + 1;

   // Monitor
   bit          prev_wr_n = 1'b1;
   bit          has_prev  = 1'b0;
   int unsigned prev_tick = 0;
   int unsigned prev_gap  = 0;
   exp_t        e;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_wr_n = 1'b1;
         has_prev  = 1'b0;
      end else begin
         if (fm_cs_o) fm_seen = 1'b1;
         if (prev_wr_n && !chip_wr_n) begin
            n_strobes++;
            fall_ticks.push_back(ticks);
            chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("fm_cs_o", 32'(fm_cs_o), 32'(e.tgt));
               chk("pcm_cs_o", 32'(pcm_cs_o), 32'(!e.tgt));
               chk("chip_din", 32'(chip_din), 32'(e.d));
               if (e.tgt) chk("chip_a0", 32'(chip_a0), 32'(e.a0));
               if (has_prev) chk("spacing_min", 32'((ticks - prev_tick) >= prev_gap + 3), 32'd1);
               prev_gap = gap_of(e);
            end
            prev_tick = ticks;
            has_prev  = 1'b1;
         end else if (!prev_wr_n && chip_wr_n) begin
            chk("strobe_width", ticks - prev_tick, 32'd1);
         end
         prev_wr_n = chip_wr_n;
      end
   end

   // CPU write; called at a negedge
   task automatic cpu_write(input bit fm, input bit pcm, input bit a0, input logic [7:0] d,
                            input int low_clks, input int gap);
      exp_t x;
      int   guard = 0;
      while (!cpu_wait_n && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 3000) chk("cpu_wait_release", 32'(cpu_wait_n), 32'd1);
      fm_cs    = fm;
      pcm_cs   = pcm;
      cpu_a0   = a0;
      cpu_dout = d;
      cpu_wr_n = 1'b0;
      x.tgt = fm;
      x.a0  = a0;
      x.d   = d;
      exp_q.push_back(x);
      repeat (low_clks) @(negedge clk);
      cpu_wr_n = 1'b1;
      fm_cs    = 1'b0;
      pcm_cs   = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while ((busy || exp_q.size() != 0) && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      repeat (8) @(negedge clk);
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_pending"}, exp_q.size(), 32'd0);
   endtask

   int unsigned base;

   initial begin
      rst_n    = 1'b0;
      fm_cen   = 1'b0;
      cpu_dout = 8'd0;
      cpu_a0   = 1'b0;
      cpu_wr_n = 1'b1;
      fm_cs    = 1'b0;
      pcm_cs   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_chip_wr_n", 32'(chip_wr_n), 32'd1);
      chk("rst_cpu_wait_n", 32'(cpu_wait_n), 32'd1);
      chk("rst_chip_din", 32'(chip_din), 32'd0);
      chk("rst_cs", {30'd0, fm_cs_o, pcm_cs_o}, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Single FM data write with a long strobe
      fall_ticks.delete();
      cpu_write(1, 0, 1, 8'h30, 20, 2);
      drain("single");
      chk("single_count", fall_ticks.size(), 32'd1);

      // FM address, data, address back to back
      fall_ticks.delete();
      cpu_write(1, 0, 0, 8'h10, 2, 2);
      cpu_write(1, 0, 1, 8'h55, 2, 2);
      cpu_write(1, 0, 0, 8'h20, 2, 2);
      drain("fm_seq");
      chk("fm_seq_count", fall_ticks.size(), 32'd3);
      if (fall_ticks.size() == 3) begin
         chk("fm_addr_gap", fall_ticks[1] - fall_ticks[0], 32'd15);
         chk("fm_data_gap", fall_ticks[2] - fall_ticks[1], 32'd87);
      end

      // PCM pair
      fall_ticks.delete();
      fm_seen = 1'b0;
      cpu_write(0, 1, 0, 8'h88, 2, 2);
      cpu_write(0, 1, 0, 8'h01, 2, 2);
      drain("pcm");
      chk("pcm_count", fall_ticks.size(), 32'd2);
      if (fall_ticks.size() == 2) chk("pcm_gap", fall_ticks[1] - fall_ticks[0], 32'd19);
      chk("pcm_no_fm_cs", 32'(fm_seen), 32'd0);

      // Both selects high: FM wins and FM address timing applies
      fall_ticks.delete();
      cpu_write(1, 1, 0, 8'h22, 2, 2);
      cpu_write(0, 1, 0, 8'h77, 2, 2);
      drain("both");
      chk("both_count", fall_ticks.size(), 32'd2);
      if (fall_ticks.size() == 2) chk("both_gap", fall_ticks[1] - fall_ticks[0], 32'd15);

      // Burst of six: the sixth write overflows into the skid
      fall_ticks.delete();
      for (int i = 0; i < 5; i++) cpu_write(1, 0, 1, 8'(8'hA0 + i), 2, 2);
      chk("burst_no_stall", 32'(cpu_wait_n), 32'd1);
      cpu_write(1, 0, 1, 8'hA5, 2, 2);
      chk("burst_stall", 32'(cpu_wait_n), 32'd0);
      chk("burst_busy", 32'(busy), 32'd1);
`ifdef JTPANG_SNDSCHED_STATS_EN
      chk("burst_stall_cnt", 32'(stall_cnt), 32'd1);
`else
      chk("burst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      drain("burst");
      chk("burst_count", fall_ticks.size(), 32'd6);
      chk("burst_wait_released", 32'(cpu_wait_n), 32'd1);

      // Reset during HOLD with three writes queued
      for (int i = 0; i < 4; i++) cpu_write(1, 0, 1, 8'(8'hC0 + i), 2, 2);
      base = n_strobes;
      for (int g = 0; g < 400 && n_strobes == base; g++) @(negedge clk);
      chk("rst_mid_first_strobe", n_strobes - base, 32'd1);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_chip_wr_n", 32'(chip_wr_n), 32'd1);
      chk("rst_mid_fm_cs_o", 32'(fm_cs_o), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      base = n_strobes;
      repeat (600) @(negedge clk);
      chk("rst_mid_no_replay", n_strobes - base, 32'd0);
      chk("rst_mid_idle", 32'(busy), 32'd0);

      // Randomized traffic with a random fm_cen
      rand_cen = 1'b1;
      fall_ticks.delete();
      for (int i = 0; i < 25; i++) begin
         int sel;
         sel = $urandom_range(0, 2);
         cpu_write(sel != 1, sel != 0, 1'($urandom_range(0, 1)), 8'($urandom),
                   $urandom_range(1, 20), $urandom_range(1, 6));
      end
      drain("random");
      chk("random_count", fall_ticks.size(), 32'd25);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
